countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Countdown counterpart of the team's count-up timer. Loads a minute:second preset on START, decrements once per tick down to 0:00, then pulses TIME_UP. Supports pause/resume and synchronous clear. Used wherever a remaining-time display is required instead of an elapsed-time display; shares the preset-input and MINUTE/SECOND output format with the count-up timer.

Parameters:
TICK_DIV, 1, SYSCLK cycles per one-second decrement (>=1); 1 = decrement every cycle, for simulation.

Ports:
SYSCLK  input  1  system clock, rising edge.
RST_B  input  1  asynchronous active-low reset.
TIME_MIN  input  3  preset minutes, 0..7.
TIME_SEC  input  6  preset seconds, valid 0..59.
START  input  1  level, sampled in IDLE only; starts countdown.
PAUSE  input  1  level; high freezes countdown.
CLEAR  input  1  synchronous abort to IDLE, highest priority.
MINUTE  output  3  remaining minutes, registered.
SECOND  output  6  remaining seconds, registered.
TIME_UP  output  1  one-cycle registered pulse on reaching 0:00.
BUSY  output  1  high in COUNT or HOLD.

Behaviour:
- Reset (RST_B low, asynchronous): state IDLE; MINUTE=0, SECOND=0, TIME_UP=0, BUSY=0, prescaler=0.
- States: IDLE, COUNT, HOLD, DONE. Encoding is 2 bits.
- Priority on every edge: CLEAR > state logic. CLEAR=1 from any state -> IDLE, MINUTE/SECOND=0, prescaler=0, TIME_UP=0 next cycle. A pending TIME_UP pulse is suppressed.
- IDLE, START=1, TIME_SEC<=59, preset nonzero -> COUNT. MINUTE/SECOND load the preset on the same edge; prescaler=0.
- IDLE, START=1, preset 0:00 -> DONE directly. TIME_UP pulses one cycle later; there is no count phase.
- IDLE, START=1, TIME_SEC>59 -> START is ignored; stay IDLE with outputs unchanged.
- IDLE, START=0 -> MINUTE/SECOND hold their last value (0:00 after completion).
- COUNT:
  - Prescaler counts 0..TICK_DIV-1 and wraps; a tick occurs at TICK_DIV-1.
  - On a tick, SECOND>0 -> SECOND-1.
  - On a tick, SECOND==0 -> SECOND=59 and MINUTE-1.
  - On a tick with current value 0:01 -> value becomes 0:00 and state becomes DONE on the same edge.
- COUNT with PAUSE=1 -> HOLD. Prescaler and value are frozen, and PAUSE beats a coincident tick (no decrement that cycle).
- HOLD with PAUSE=0 -> COUNT. The prescaler resumes from its frozen value.
- START is ignored in COUNT, HOLD and DONE.
- DONE: TIME_UP=1 for exactly this one cycle; next state is IDLE. MINUTE/SECOND read 0:00.
- Latency: with N = preset total seconds (MINUTE*60+SECOND, N>=1), TIME_UP rises 1 + N*TICK_DIV edges after the edge sampling START, plus any cycles spent in HOLD.
- Widths: the internal total never underflows. The 0:00 check precedes decrement, so MINUTE never wraps past 0. The prescaler width is clog2(TICK_DIV), minimum 1.
- BUSY is registered alongside state and is 0 in IDLE and DONE.

Optional Feature:
AUTO_RELOAD_EN
- Defined:
  - The preset is captured into internal registers at START.
  - DONE loads the captured preset into MINUTE/SECOND and returns to COUNT instead of IDLE, while still pulsing TIME_UP for the one DONE cycle.
  - Operation is periodic and only CLEAR stops it.
  - A captured preset of 0:00 does not reload; DONE -> IDLE.
- Undefined: no capture registers; DONE -> IDLE always.

Test Plan:
- TICK_DIV=1, preset 0:03, START 1 cycle -> MINUTE:SECOND read 0:03, 0:02, 0:01, 0:00. TIME_UP is high for 1 cycle, 4 edges after START; BUSY is high for 3 cycles.
- TICK_DIV=1, preset 1:00 -> 0:59 follows 1:00 (minute borrow). TIME_UP is high 61 edges after START.
- TICK_DIV=4, preset 0:02, PAUSE high 5 cycles mid-count -> value frozen during PAUSE; TIME_UP at 1+8+5=14 edges.
- START with preset 0:00 -> no COUNT; TIME_UP pulse 1 cycle later. START with TIME_SEC=60 -> stays IDLE, no pulse.
- CLEAR asserted during COUNT at 0:01 coincident with the final tick -> IDLE, 0:00, TIME_UP stays 0. RST_B low mid-count -> outputs 0 immediately, without waiting for a clock edge.
- AUTO_RELOAD_EN, preset 0:02, TICK_DIV=1 -> TIME_UP every 3 cycles and value reloads to 0:02; CLEAR stops it.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loads a MM:SS preset on START, counts down once per tick to 0:00, then pulses TIME_UP.
// Build option AUTO_RELOAD_EN: capture the preset at START and restart from it after every expiry.
module countdown_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic       SYSCLK,
  input  logic       RST_B,
  input  logic [2:0] TIME_MIN,
  input  logic [5:0] TIME_SEC,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       CLEAR,
  output logic [2:0] MINUTE,
  output logic [5:0] SECOND,
  output logic       TIME_UP,
  output logic       BUSY
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [2:0]    minute_nxt;
  logic [5:0]    second_nxt;
  logic          time_up_nxt;
  logic          busy_nxt;

  logic          preset_ok;
  logic          preset_zero;
  logic          accept;
  logic          run;
  logic          tick;
  logic          at_last;

  logic          reload_en;
  logic [2:0]    reload_min;
  logic [5:0]    reload_sec;

  // Borrowing decrement of an MM:SS value; 0:01 and 0:00 both land on 0:00 so minutes never wrap.
  function automatic logic [8:0] dec_mmss(input logic [2:0] m, input logic [5:0] s);
    if (m == 3'd0 && s <= 6'd1) begin
      return 9'd0;
    end else if (s == 6'd0) begin
      return {m - 3'd1, 6'd59};
    end else begin
      return {m, s - 6'd1};
    end
  endfunction

  assign preset_ok   = (TIME_SEC <= 6'd59);
  assign preset_zero = (TIME_MIN == 3'd0) && (TIME_SEC == 6'd0);
  assign accept      = (state == IDLE) && START && preset_ok && !CLEAR;
  assign run         = ((state == COUNT) || (state == HOLD)) && !PAUSE;
  assign tick        = run && (presc == TICK_LAST);
  assign at_last     = (MINUTE == 3'd0) && (SECOND <= 6'd1);

`ifdef AUTO_RELOAD_EN
  logic [2:0] cap_min;
  logic [5:0] cap_sec;

  // Preset snapshot for periodic restarts; only read in DONE, which is reachable only after a capture.
  always_ff @(posedge SYSCLK) begin
    if (accept) begin
      cap_min <= TIME_MIN;
      cap_sec <= TIME_SEC;
    end
  end

  assign reload_en  = (cap_min != 3'd0) || (cap_sec != 6'd0);
  assign reload_min = cap_min;
  assign reload_sec = cap_sec;
`else
  assign reload_en  = 1'b0;
  assign reload_min = 3'd0;
  assign reload_sec = 6'd0;
`endif

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state   <= IDLE;
      presc   <= '0;
      MINUTE  <= 3'd0;
      SECOND  <= 6'd0;
      TIME_UP <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      MINUTE  <= minute_nxt;
      SECOND  <= second_nxt;
      TIME_UP <= time_up_nxt;
      BUSY    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (CLEAR) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (START && preset_ok) begin
            state_nxt = preset_zero ? DONE : COUNT;
          end
        end
        COUNT, HOLD: begin
          if (PAUSE) begin
            state_nxt = HOLD;
          end else if (tick && at_last) begin
            state_nxt = DONE;
          end else begin
            state_nxt = COUNT;
          end
        end
        DONE: begin
          state_nxt = reload_en ? COUNT : IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // A HOLD edge with PAUSE low already counts, so a pause costs exactly the cycles PAUSE was high.
  always_comb begin
    presc_nxt   = presc;
    minute_nxt  = MINUTE;
    second_nxt  = SECOND;
    time_up_nxt = (state == DONE) && !CLEAR;
    busy_nxt    = (state_nxt == COUNT) || (state_nxt == HOLD);
    if (CLEAR) begin
      presc_nxt  = '0;
      minute_nxt = 3'd0;
      second_nxt = 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            minute_nxt = TIME_MIN;
            second_nxt = TIME_SEC;
            presc_nxt  = '0;
          end
        end
        COUNT, HOLD: begin
          if (run) begin
            presc_nxt = tick ? '0 : presc + 1'b1;
            if (tick) begin
              {minute_nxt, second_nxt} = dec_mmss(MINUTE, SECOND);
            end
          end
        end
        DONE: begin
          presc_nxt  = '0;
          minute_nxt = reload_min;
          second_nxt = reload_sec;
        end
        default: begin
          presc_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (TICK_DIV=1 and 4) on shared inputs against a seconds-based model.
module tb_countdown_timer;

  logic        SYSCLK = 1'b0;
  logic        RST_B;
  logic [2:0]  TIME_MIN;
  logic [5:0]  TIME_SEC;
  logic        START;
  logic        PAUSE;
  logic        CLEAR;
  logic [2:0]  min_a, min_b;
  logic [5:0]  sec_a, sec_b;
  logic        up_a, up_b, busy_a, busy_b;
  logic [10:0] obs_a, obs_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: remaining time as a plain count of seconds plus elapsed cycles within the current second.
  int rem[2];
  int sub[2];
  int cap[2];
  bit active[2];
  bit finishing[2];
  bit up[2];
  int td[2] = '{1, 4};

  always #5 SYSCLK = ~SYSCLK;

  assign obs_a = {min_a, sec_a, up_a, busy_a};
  assign obs_b = {min_b, sec_b, up_b, busy_b};

  countdown_timer #(.TICK_DIV(1)) dut_a (
    .SYSCLK(SYSCLK), .RST_B(RST_B), .TIME_MIN(TIME_MIN), .TIME_SEC(TIME_SEC),
    .START(START), .PAUSE(PAUSE), .CLEAR(CLEAR),
    .MINUTE(min_a), .SECOND(sec_a), .TIME_UP(up_a), .BUSY(busy_a)
  );

  countdown_timer #(.TICK_DIV(4)) dut_b (
    .SYSCLK(SYSCLK), .RST_B(RST_B), .TIME_MIN(TIME_MIN), .TIME_SEC(TIME_SEC),
    .START(START), .PAUSE(PAUSE), .CLEAR(CLEAR),
    .MINUTE(min_b), .SECOND(sec_b), .TIME_UP(up_b), .BUSY(busy_b)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; sub[k] = 0; active[k] = 0; finishing[k] = 0; up[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit was_fin;
      was_fin = finishing[k];
      up[k] = 0;
      if (CLEAR) begin
        rem[k] = 0; sub[k] = 0; active[k] = 0; finishing[k] = 0;
      end else if (was_fin) begin
        up[k] = 1;
        finishing[k] = 0;
`ifdef AUTO_RELOAD_EN
        if (cap[k] > 0) begin
          rem[k] = cap[k]; sub[k] = 0; active[k] = 1;
        end
`endif
      end else if (active[k]) begin
        if (!PAUSE) begin
          sub[k]++;
          if (sub[k] == td[k]) begin
            sub[k] = 0;
            rem[k]--;
            if (rem[k] == 0) begin
              active[k] = 0; finishing[k] = 1;
            end
          end
        end
      end else if (START && TIME_SEC <= 59) begin
        rem[k] = int'(TIME_MIN) * 60 + int'(TIME_SEC);
        cap[k] = rem[k];
        sub[k] = 0;
        if (rem[k] == 0) finishing[k] = 1;
        else active[k] = 1;
      end
    end
  endtask

  function automatic logic [10:0] exp_vec(input int k);
    logic [2:0] m;
    logic [5:0] s;
    m = 3'(rem[k] / 60);
    s = 6'(rem[k] % 60);
    return {m, s, up[k], active[k]};
  endfunction

  task automatic step(input bit s, input bit p, input bit c);
    START = s; PAUSE = p; CLEAR = c;
    @(posedge SYSCLK);
    model_edge();
    #1;
  endtask

  task automatic flush();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    RST_B = 0; START = 0; PAUSE = 0; CLEAR = 0; TIME_MIN = 3'd0; TIME_SEC = 6'd0;
    model_reset();
    repeat (2) @(posedge SYSCLK);
    #1;
    if (obs_a !== 11'd0) $display("FAIL reset_a got=%b want=0", obs_a); else n_pass++;
    if (obs_b !== 11'd0) $display("FAIL reset_b got=%b want=0", obs_b); else n_pass++;
    n_checks += 2;
    RST_B = 1;
  endtask

  task automatic test_basic();
    int up_at;
    int busy_cnt;
    int seq[4];
    up_at = -1; busy_cnt = 0;
    TIME_MIN = 3'd0; TIME_SEC = 6'd3;
    for (int i = 0; i <= 6; i++) begin
      step(i == 0, 0, 0);
      if (obs_a !== exp_vec(0)) $display("FAIL basic_a edge=%0d got=%b want=%b", i, obs_a, exp_vec(0)); else n_pass++;
      if (obs_b !== exp_vec(1)) $display("FAIL basic_b edge=%0d got=%b want=%b", i, obs_b, exp_vec(1)); else n_pass++;
      n_checks += 2;
      if (i < 4) begin
        seq[i] = int'(min_a) * 60 + int'(sec_a);
        if (busy_a === 1'b1) busy_cnt++;
      end
      if (up_a === 1'b1 && up_at < 0) up_at = i;
    end
    for (int i = 0; i < 4; i++) begin
      if (seq[i] !== 3 - i) $display("FAIL basic_seq edge=%0d got=%0d want=%0d", i, seq[i], 3 - i); else n_pass++;
      n_checks++;
    end
    if (up_at !== 4) $display("FAIL basic_up_edge got=%0d want=4", up_at); else n_pass++;
    if (busy_cnt !== 3) $display("FAIL basic_busy_cycles got=%0d want=3", busy_cnt); else n_pass++;
    n_checks += 2;
    flush();
  endtask

  task automatic test_borrow();
    int up_at;
    up_at = -1;
    TIME_MIN = 3'd1; TIME_SEC = 6'd0;
    for (int i = 0; i <= 70; i++) begin
      step(i == 0, 0, 0);
      if (obs_a !== exp_vec(0)) $display("FAIL borrow_a edge=%0d got=%b want=%b", i, obs_a, exp_vec(0)); else n_pass++;
      if (obs_b !== exp_vec(1)) $display("FAIL borrow_b edge=%0d got=%b want=%b", i, obs_b, exp_vec(1)); else n_pass++;
      n_checks += 2;
      if (i == 1) begin
        if ({min_a, sec_a} !== {3'd0, 6'd59}) $display("FAIL borrow_059 got=%0d:%0d want=0:59", min_a, sec_a); else n_pass++;
        n_checks++;
      end
      if (up_a === 1'b1 && up_at < 0) up_at = i;
    end
    if (up_at !== 61) $display("FAIL borrow_up_edge got=%0d want=61", up_at); else n_pass++;
    n_checks++;
    flush();
  endtask

  task automatic test_pause();
    int up_at;
    up_at = -1;
    TIME_MIN = 3'd0; TIME_SEC = 6'd2;
    for (int i = 0; i <= 20; i++) begin
      step(i == 0, (i >= 4 && i <= 8), 0);
      if (obs_a !== exp_vec(0)) $display("FAIL pause_a edge=%0d got=%b want=%b", i, obs_a, exp_vec(0)); else n_pass++;
      if (obs_b !== exp_vec(1)) $display("FAIL pause_b edge=%0d got=%b want=%b", i, obs_b, exp_vec(1)); else n_pass++;
      n_checks += 2;
      if (i == 8) begin
        if ({min_b, sec_b, busy_b} !== {3'd0, 6'd2, 1'b1}) $display("FAIL pause_frozen got=%0d:%0d busy=%b want=0:2 busy=1", min_b, sec_b, busy_b); else n_pass++;
        n_checks++;
      end
      if (up_b === 1'b1 && up_at < 0) up_at = i;
    end
    if (up_at !== 14) $display("FAIL pause_up_edge got=%0d want=14", up_at); else n_pass++;
    n_checks++;
    flush();
  endtask

  task automatic test_edge_presets();
    TIME_MIN = 3'd0; TIME_SEC = 6'd0;
    for (int i = 0; i < 3; i++) begin
      step(i == 0, 0, 0);
      if (obs_a !== exp_vec(0)) $display("FAIL zero_a edge=%0d got=%b want=%b", i, obs_a, exp_vec(0)); else n_pass++;
      if (obs_b !== exp_vec(1)) $display("FAIL zero_b edge=%0d got=%b want=%b", i, obs_b, exp_vec(1)); else n_pass++;
      if ({up_a, busy_a} !== {(i == 1), 1'b0}) $display("FAIL zero_pulse edge=%0d got up=%b busy=%b want up=%b busy=0", i, up_a, busy_a, (i == 1)); else n_pass++;
      n_checks += 3;
    end
    TIME_MIN = 3'd2; TIME_SEC = 6'd60;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      if (obs_a !== exp_vec(0)) $display("FAIL sec60_a edge=%0d got=%b want=%b", i, obs_a, exp_vec(0)); else n_pass++;
      if (obs_b !== exp_vec(1)) $display("FAIL sec60_b edge=%0d got=%b want=%b", i, obs_b, exp_vec(1)); else n_pass++;
      if (obs_a !== 11'd0) $display("FAIL sec60_idle got=%b want=0", obs_a); else n_pass++;
      n_checks += 3;
    end
    flush();
  endtask

  task automatic test_clear_final();
    TIME_MIN = 3'd0; TIME_SEC = 6'd2;
    step(1, 0, 0);
    step(0, 0, 0);
    if ({min_a, sec_a} !== {3'd0, 6'd1}) $display("FAIL clear_pre got=%0d:%0d want=0:1", min_a, sec_a); else n_pass++;
    n_checks++;
    step(0, 0, 1);
    if (obs_a !== 11'd0) $display("FAIL clear_final_a got=%b want=0", obs_a); else n_pass++;
    if (obs_b !== exp_vec(1)) $display("FAIL clear_final_b got=%b want=%b", obs_b, exp_vec(1)); else n_pass++;
    n_checks += 2;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      if (obs_a !== 11'd0) $display("FAIL clear_no_pulse edge=%0d got=%b want=0", i, obs_a); else n_pass++;
      if (obs_b !== exp_vec(1)) $display("FAIL clear_after_b edge=%0d got=%b want=%b", i, obs_b, exp_vec(1)); else n_pass++;
      n_checks += 2;
    end
  endtask

  task automatic test_async_reset();
    TIME_MIN = 3'd0; TIME_SEC = 6'd5;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    #2;
    RST_B = 0;
    #1;
    if (obs_a !== 11'd0) $display("FAIL async_rst_a got=%b want=0", obs_a); else n_pass++;
    if (obs_b !== 11'd0) $display("FAIL async_rst_b got=%b want=0", obs_b); else n_pass++;
    n_checks += 2;
    model_reset();
    step(0, 0, 0);
    RST_B = 1;
    step(0, 0, 0);
    if (obs_a !== exp_vec(0)) $display("FAIL async_after_a got=%b want=%b", obs_a, exp_vec(0)); else n_pass++;
    if (obs_b !== exp_vec(1)) $display("FAIL async_after_b got=%b want=%b", obs_b, exp_vec(1)); else n_pass++;
    n_checks += 2;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        TIME_MIN = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
        TIME_SEC = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
      if (obs_a !== exp_vec(0)) $display("FAIL random_a cyc=%0d got=%b want=%b", i, obs_a, exp_vec(0)); else n_pass++;
      if (obs_b !== exp_vec(1)) $display("FAIL random_b cyc=%0d got=%b want=%b", i, obs_b, exp_vec(1)); else n_pass++;
      n_checks += 2;
    end
    flush();
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_reload();
    TIME_MIN = 3'd0; TIME_SEC = 6'd2;
    for (int i = 0; i <= 12; i++) begin
      step(i == 0, 0, 0);
      if (obs_a !== exp_vec(0)) $display("FAIL reload_a edge=%0d got=%b want=%b", i, obs_a, exp_vec(0)); else n_pass++;
      if (obs_b !== exp_vec(1)) $display("FAIL reload_b edge=%0d got=%b want=%b", i, obs_b, exp_vec(1)); else n_pass++;
      n_checks += 2;
      if (i > 0 && i % 3 == 0) begin
        if ({up_a, min_a, sec_a} !== {1'b1, 3'd0, 6'd2}) $display("FAIL reload_period edge=%0d got up=%b %0d:%0d want up=1 0:2", i, up_a, min_a, sec_a); else n_pass++;
        n_checks++;
      end
    end
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      if (obs_a !== 11'd0) $display("FAIL reload_stop edge=%0d got=%b want=0", i, obs_a); else n_pass++;
      n_checks++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_edge_presets();
    test_clear_final();
    test_async_reset();
`ifdef AUTO_RELOAD_EN
    test_reload();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
